// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : MIPS memory stage with internal word-addressed data RAM,
//            configurable wait states and MEM/WB pipeline register.
//            Optional misalignment trap enabled by defining the macro
//            DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic        MisalignErr
);

  localparam int       c_AW      = $clog2(DEPTH);
  localparam logic [3:0] c_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH];

  logic        regwrite_q;
  logic        memtoreg_q;
  logic [31:0] readdata_q;
  logic [31:0] aluout_q;
  logic [4:0]  writereg_q;

  logic            w_access;
  logic            w_is_store;
  logic            w_is_load;
  logic            w_stall;
  logic            w_complete;
  logic            w_trap_misalign;
  logic [c_AW-1:0] w_index;
  logic [31:0]     w_load_data;

  // A store wins over a load when both strobes are set.
  assign w_access   = MemtoRegM | MemWriteM;
  assign w_is_store = MemWriteM;
  assign w_is_load  = MemtoRegM & ~MemWriteM;
  assign w_index    = ALUOutM[c_AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;

  assign w_trap_misalign = (ALUOutM[1:0] != 2'b00);

  // Sticky misalignment flag, set when a misaligned access completes.
  always_ff @(posedge clk) begin
    if (!RST) begin
      misalign_q <= 1'b0;
    end else if (w_complete && w_trap_misalign) begin
      misalign_q <= 1'b1;
    end
  end

  assign MisalignErr = misalign_q;
`else
  assign w_trap_misalign = 1'b0;
  assign MisalignErr     = 1'b0;
`endif

  // Access sequencer state register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, stall request and completion strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_stall    = 1'b0;
    w_complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_access) begin
          if (WAIT_STATES == 0) begin
            w_complete = 1'b1;
          end else begin
            w_stall = 1'b1;
            cnt_d   = c_CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          w_stall = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          w_complete = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Nothing stalls or completes while reset is asserted.
    if (!RST) begin
      w_stall    = 1'b0;
      w_complete = 1'b0;
    end
  end

  assign StallM = w_stall;

  // Data RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_complete && w_is_store && !w_trap_misalign) begin
      mem_q[w_index] <= WriteDataM;
    end
  end

  // Load data is only captured on the completion edge of a real load.
  assign w_load_data = (w_complete && w_is_load && !w_trap_misalign) ? mem_q[w_index] : 32'd0;

  // MEM/WB register: bubble on stall or reset, otherwise capture the instruction.
  always_ff @(posedge clk) begin
    if (!RST || w_stall) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      readdata_q <= 32'd0;
      aluout_q   <= 32'd0;
      writereg_q <= 5'd0;
    end else begin
      regwrite_q <= RegWriteM;
      memtoreg_q <= MemtoRegM;
      readdata_q <= w_load_data;
      aluout_q   <= ALUOutM;
      writereg_q <= WriteRegM;
    end
  end

  assign RegWriteW = regwrite_q;
  assign MemtoRegW = memtoreg_q;
  assign ReadDataW = readdata_q;
  assign ALUOutW   = aluout_q;
  assign WriteRegW = writereg_q;
  assign ResultW   = memtoreg_q ? readdata_q : aluout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Scoreboard testbench for mem_wb_stage with a word-array memory
//            model; honours DMEM_MISALIGN_TRAP_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  localparam int DEPTH = 256;
  localparam int WS    = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        StallM, RegWriteW, MemtoRegW, MisalignErr;
  logic [31:0] ReadDataW, ALUOutW, ResultW;
  logic [4:0]  WriteRegW;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .RST(RST),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .MisalignErr(MisalignErr)
  );

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ref_mem [DEPTH];
  bit          ref_mis  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word memory indexed by byte address / 4, wrapping at DEPTH.
  task automatic model_push(input bit rw, input bit m2r, input bit mw,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    exp_t e;
    int   idx = int'((alu / 4) % DEPTH);
    bit   mis = TRAP && (m2r || mw) && (alu % 4 != 0);
    e.rw = rw; e.m2r = m2r; e.alu = alu; e.wr = wr; e.rdata = 32'd0;
    if (mw) begin
      if (!mis) ref_mem[idx] = wd;
    end else if (m2r) begin
      e.rdata = mis ? 32'd0 : ref_mem[idx];
    end
    ref_mis = ref_mis | mis;
    e.mis = ref_mis;
    exp_q.push_back(e);
  endtask

  // Count stall cycles until the stage lets the instruction complete.
  task automatic wait_done(input int exp_n);
    int n = 0;
    @(negedge clk);
    while (StallM === 1'b1 && n < WS + 10) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, exp_n);
  endtask

  task automatic drive(input bit rw, input bit m2r, input bit mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
  endtask

  task automatic do_op(input bit rw, input bit m2r, input bit mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    drive(rw, m2r, mw, alu, wd, wr);
    wait_done((m2r || mw) ? WS : 0);
    model_push(rw, m2r, mw, alu, wd, wr);
    @(posedge clk); #1;
  endtask

  // Store to 0x20 interrupted by reset in its second wait cycle.
  task automatic reset_mid_wait(input bit keep);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 5'd0);
    @(negedge clk); chk("rst_t_stall_a", StallM, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rst_t_stall_b", StallM, 1);
    @(posedge clk); #1;
    RST = 1'b0;
    ref_mis = 1'b0;
    if (!keep) drive(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 5'd7);
    @(negedge clk); chk("rst_stall_low", StallM, 0);
    @(posedge clk); #1;
    RST = 1'b1;
    wait_done(WS);
    model_push(RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM);
    @(posedge clk); #1;
  endtask

  // Monitor: judges the W outputs produced by the previous cycle.
  bit have_prev = 1'b0;
  bit prev_stall, prev_rst;
  always @(negedge clk) begin
    exp_t e;
    if (have_prev) begin
      if (prev_rst) begin
        chk("rst_RegWriteW", RegWriteW, 0);
        chk("rst_MemtoRegW", MemtoRegW, 0);
        chk("rst_ReadDataW", ReadDataW, 0);
        chk("rst_ALUOutW", ALUOutW, 0);
        chk("rst_WriteRegW", WriteRegW, 0);
        chk("rst_MisalignErr", MisalignErr, 0);
      end else if (prev_stall) begin
        chk("bub_RegWriteW", RegWriteW, 0);
        chk("bub_MemtoRegW", MemtoRegW, 0);
        chk("bub_ReadDataW", ReadDataW, 0);
        chk("bub_ALUOutW", ALUOutW, 0);
        chk("bub_WriteRegW", WriteRegW, 0);
        chk("bub_ResultW", ResultW, 0);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got ALUOutW %h expected no completion", ALUOutW);
      end else begin
        e = exp_q.pop_front();
        chk("RegWriteW", RegWriteW, e.rw);
        chk("MemtoRegW", MemtoRegW, e.m2r);
        chk("ReadDataW", ReadDataW, e.rdata);
        chk("ALUOutW", ALUOutW, e.alu);
        chk("WriteRegW", WriteRegW, e.wr);
        chk("ResultW", ResultW, e.m2r ? e.rdata : e.alu);
        chk("MisalignErr", MisalignErr, e.mis);
      end
    end
    prev_stall = (StallM === 1'b1);
    prev_rst   = !RST;
    have_prev  = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, w;
    logic [31:0] a;
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b1;

    // Give a known value to the words the random phase touches.
    for (int i = 0; i < 16; i++) do_op(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0);

    do_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd9);
    do_op(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0);
    do_op(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd5);
    do_op(1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 5'd0);
    do_op(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 5'd3);

    reset_mid_wait(1'b0);
    reset_mid_wait(1'b1);
    do_op(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 5'd8);

    do_op(1'b0, 1'b0, 1'b1, 32'h22, 32'h7777_0000, 5'd0);
    do_op(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 5'd4);
    do_op(1'b1, 1'b1, 1'b0, 32'h21, 32'd0, 5'd6);
    do_op(1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 32'd0, 5'd2);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom % 8);
      w    = int'($urandom % 16);
      a    = 32'(w * 4) + 32'(($urandom % 4) * DEPTH * 4);
      if ($urandom % 4 == 0) a = a + ($urandom % 4);
      if (kind < 3)      do_op(1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 5'($urandom));
      else if (kind < 5) do_op(1'b1, 1'b1, 1'b0, a, $urandom, 5'($urandom));
      else if (kind < 7) do_op(1'($urandom), 1'b0, 1'b1, a, $urandom, 5'($urandom));
      else               do_op(1'b0, 1'b1, 1'b1, a, $urandom, 5'($urandom));
    end

    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory stage plus MEM/WB pipeline register of the pipelined MIPS core. It consumes the EX/MEM register outputs and performs word loads and stores against an internal data RAM. The RAM has a configurable number of wait states, and the block stalls upstream stages while an access is pending. It registers load data, ALU result, destination register and control into the writeback stage, and drives the final writeback result.

## Interface
- DEPTH, 256: data RAM size in 32-bit words; power of two.
- WAIT_STATES, 0: extra cycles each load/store occupies the stage (0..15).
- clk  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-low.
- RegWriteM  in  1  instruction in MEM writes the register file.
- MemtoRegM  in  1  instruction in MEM is a load.
- MemWriteM  in  1  instruction in MEM is a store.
- ALUOutM  in  32  byte address for load/store, else result.
- WriteDataM  in  32  store data.
- WriteRegM  in  5  destination register.
- StallM  out  1  combinational; 1 = hold PC, IF/ID, ID/EX, EX/MEM this cycle.
- RegWriteW  out  1  registered.
- MemtoRegW  out  1  registered.
- ReadDataW  out  32  registered load data.
- ALUOutW  out  32  registered.
- WriteRegW  out  5  registered.
- ResultW  out  32  combinational: MemtoRegW ? ReadDataW : ALUOutW.
- MisalignErr  out  1  registered sticky flag (see Configuration).

## Operation
- Access = MemtoRegM | MemWriteM. MemtoRegM and MemWriteM never both 1; if both are 1, the store takes precedence and no load data is captured.
- RAM index = ALUOutM[log2(DEPTH)+1:2]. Bits [1:0] are ignored. Higher bits are ignored, so addresses wrap modulo DEPTH words.
- RAM contents are not reset.
- FSM states:
  - IDLE:
    - Access with WAIT_STATES>0: StallM=1, cnt<=WAIT_STATES-1, go to WAIT.
    - Access with WAIT_STATES=0: completes this cycle.
    - No access: StallM=0.
  - WAIT:
    - cnt!=0: StallM=1, cnt<=cnt-1.
    - cnt==0: StallM=0, access completes, go to IDLE.
- Completion edge:
  - Store: RAM[index]<=WriteDataM.
  - Load: ReadDataW<=RAM[index].
  - MEM/WB loads RegWriteM, MemtoRegM, ALUOutM and WriteRegM.
- Non-access cycle: MEM/WB loads the inputs; ReadDataW<=0.
- Stall cycle (StallM=1): MEM/WB loads a bubble, with all W outputs 0. No RAM write.
- Inputs are held stable by upstream while StallM=1.

## Timing
- Non-memory instruction: 1 cycle MEM to W, no stall.
- Load/store: WAIT_STATES+1 cycles in MEM. StallM is high for exactly WAIT_STATES cycles, and W outputs update on the final edge.
- Back-to-back accesses: each is handled independently.
- A load following a store to the same word sees the stored data, because the write completes on an earlier edge.
- Reset (RST=0 at an edge):
  - state<=IDLE, cnt<=0.
  - All registered outputs <=0, including MisalignErr.
  - A pending store is dropped, with no RAM write.
- StallM=0 while RST=0.
- Reset mid-WAIT aborts the access. After RST returns to 1, a still-present access restarts with a full WAIT_STATES count.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - An access with ALUOutM[1:0]!=0 sets MisalignErr on its completion edge; the flag holds until reset.
  - A misaligned store does not write RAM.
  - A misaligned load returns ReadDataW=0.
- DMEM_MISALIGN_TRAP_EN not defined:
  - MisalignErr is tied to 0.
  - Low address bits are ignored; a misaligned access behaves as the aligned one.

## Test plan
- WAIT_STATES=0: store 0xDEADBEEF to 0x10, then load 0x10 with WriteRegM=5 -> StallM never 1; at load completion ReadDataW=0xDEADBEEF, WriteRegW=5, ResultW=0xDEADBEEF.
- WAIT_STATES=3: load issued -> StallM=1 for 3 consecutive cycles, W outputs 0 during those cycles, data valid on the 4th edge.
- ALU op with ALUOutM=0x1234, RegWriteM=1, WriteRegM=9 -> next cycle RegWriteW=1, WriteRegW=9, ResultW=0x1234, ReadDataW=0.
- DEPTH=256: store 0xA5A5A5A5 to 0x400, then load 0x0 -> returns 0xA5A5A5A5 (wrap-around).
- WAIT_STATES=3: RST=0 during the 2nd wait cycle of a store to 0x20 -> RAM[8] unchanged, all outputs 0, StallM=0; the access restarts after RST=1.
- With DMEM_MISALIGN_TRAP_EN: store to 0x22 -> RAM unchanged, MisalignErr=1 and stays 1. Without it -> RAM[8] written, MisalignErr=0.
